// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants and FSM state type for the binary32 multiplier path
package fp_mul_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int PROD_W  = 48;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      PACK  = 2'd3
   } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even increment of a fraction given guard and sticky
module fp_round_rne #(
   parameter int MAN_W = 23
) (
   input  logic [MAN_W-1:0] frac_i,
   input  logic             guard_i,
   input  logic             sticky_i,
   output logic [MAN_W-1:0] frac_o,
   output logic             carry_o
);

   logic inc;

   // Exact ties go up only when that makes the LSB even.
   assign inc = guard_i & (sticky_i | frac_i[0]);
   assign {carry_o, frac_o} = {1'b0, frac_i} + (MAN_W+1)'(inc);

endmodule

// File: rtl/fp_norm_round_pack.sv
// rtl/fp_norm_round_pack.sv - normalize, round (RNE) and pack a mantissa product into binary32
module fp_norm_round_pack #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = 127
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic [2*(MAN_W+1)-1:0]   Product_in,
   input  logic                     Sign_a,
   input  logic                     Sign_b,
   input  logic [EXP_W-1:0]         Exp_a,
   input  logic [EXP_W-1:0]         Exp_b,
   output logic [EXP_W+MAN_W:0]     Out_F,
   output logic                     DoneO,
   output logic                     Busy,
   output logic                     Overflow,
   output logic                     Underflow
);

   import fp_mul_pkg::*;

   localparam int PW = 2*(MAN_W+1);
   localparam int EW = EXP_W+2;
   localparam int GI = PW-3-MAN_W;
   localparam logic [EXP_W-1:0] EMAX = '1;

   state_t                 state_q, state_d;
   logic [PW-1:0]          prod_q, prod_d;
   logic                   sign_q, sign_d;
   logic [EXP_W-1:0]       exp_a_q, exp_a_d, exp_b_q, exp_b_d;
   logic [EW-1:0]          exp_q, exp_d;
   logic [MAN_W-1:0]       frac_q, frac_d;
   logic                   g_q, g_d, s_q, s_d;
   logic [EXP_W+MAN_W:0]   out_q, out_d;
   logic                   done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;

   logic [PW-1:0]          p_norm;
   logic [EW-1:0]          e_base;
   logic [MAN_W-1:0]       frac_rnd;
   logic                   rnd_carry;
   logic                   a_inf, b_inf, a_zero, b_zero;

   fp_round_rne #(.MAN_W(MAN_W)) u_round (
      .frac_i   (frac_q),
      .guard_i  (g_q),
      .sticky_i (s_q),
      .frac_o   (frac_rnd),
      .carry_o  (rnd_carry)
   );

   // Leading one ends up at bit PW-2; E is kept two bits wider so it can go negative.
   assign p_norm = prod_q[PW-1] ? (prod_q >> 1) : prod_q;
   assign e_base = {2'b00, exp_a_q} + {2'b00, exp_b_q} - EW'(BIAS);
   assign a_inf  = (exp_a_q == EMAX);
   assign b_inf  = (exp_b_q == EMAX);
   assign a_zero = (exp_a_q == '0);
   assign b_zero = (exp_b_q == '0);

   always_comb begin
      state_d = state_q;
      prod_d  = prod_q;
      sign_d  = sign_q;
      exp_a_d = exp_a_q;
      exp_b_d = exp_b_q;
      exp_d   = exp_q;
      frac_d  = frac_q;
      g_d     = g_q;
      s_d     = s_q;
      out_d   = out_q;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               prod_d  = Product_in;
               sign_d  = Sign_a ^ Sign_b;
               exp_a_d = Exp_a;
               exp_b_d = Exp_b;
               state_d = NORM;
            end
         end
         NORM: begin
            exp_d   = e_base + EW'(prod_q[PW-1]);
            frac_d  = p_norm[PW-3 -: MAN_W];
            g_d     = p_norm[GI];
            s_d     = |p_norm[GI-1:0];
            state_d = ROUND;
         end
         ROUND: begin
            frac_d  = frac_rnd;
            exp_d   = exp_q + EW'(rnd_carry);
            state_d = PACK;
         end
         PACK: begin
            done_d = 1'b1;
            if ((a_inf && b_zero) || (b_inf && a_zero)) begin
               out_d = {1'b0, EMAX, 1'b1, (MAN_W-1)'(0)};
            end else if (a_inf || b_inf) begin
               out_d = {sign_q, EMAX, MAN_W'(0)};
            end else if (a_zero || b_zero) begin
               out_d = {sign_q, (EXP_W+MAN_W)'(0)};
            end else if ($signed(exp_q) >= $signed({2'b00, EMAX})) begin
               out_d = {sign_q, EMAX, MAN_W'(0)};
               ovf_d = 1'b1;
            end else if ($signed(exp_q) <= $signed(EW'(0))) begin
               out_d = {sign_q, (EXP_W+MAN_W)'(0)};
               unf_d = 1'b1;
            end else begin
               out_d = {sign_q, exp_q[EXP_W-1:0], frac_q};
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         prod_q  <= '0;
         sign_q  <= 1'b0;
         exp_a_q <= '0;
         exp_b_q <= '0;
         exp_q   <= '0;
         frac_q  <= '0;
         g_q     <= 1'b0;
         s_q     <= 1'b0;
         out_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
         sign_q  <= sign_d;
         exp_a_q <= exp_a_d;
         exp_b_q <= exp_b_d;
         exp_q   <= exp_d;
         frac_q  <= frac_d;
         g_q     <= g_d;
         s_q     <= s_d;
         out_q   <= out_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign Out_F     = out_q;
   assign DoneO     = done_q;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;
   assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// tb/tb_fp_norm_round_pack.sv - directed vector bench for fp_norm_round_pack
module tb_fp_norm_round_pack;

   logic        CLK = 1'b0;
   logic        Reset, Start, Sign_a, Sign_b;
   logic [47:0] Product_in;
   logic [7:0]  Exp_a, Exp_b;
   logic [31:0] Out_F;
   logic        DoneO, Busy, Overflow, Underflow;

   int total  = 0;
   int passed = 0;

   typedef struct {
      string       name;
      logic [47:0] prod;
      logic        sa, sb;
      logic [7:0]  ea, eb;
      logic [31:0] out;
      logic        ovf, unf;
   } vec_t;

   vec_t vecs[$];

   fp_norm_round_pack dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Product_in(Product_in),
      .Sign_a(Sign_a), .Sign_b(Sign_b), .Exp_a(Exp_a), .Exp_b(Exp_b),
      .Out_F(Out_F), .DoneO(DoneO), .Busy(Busy),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input string n, input logic [47:0] p, input logic sa, input logic sb,
                               input logic [7:0] ea, input logic [7:0] eb, input logic [31:0] o,
                               input logic ov, input logic un);
      vec_t v;
      v.name = n; v.prod = p; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
      v.out = o; v.ovf = ov; v.unf = un;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input vec_t v);
      Product_in = v.prod; Sign_a = v.sa; Sign_b = v.sb; Exp_a = v.ea; Exp_b = v.eb;
      Start = 1'b1;
   endtask

   // Called at a falling edge; returns at the falling edge where DoneO is seen (or the budget ran out).
   task automatic run_op(input vec_t v, output logic [31:0] o, output logic ov, output logic un,
                         output int lat);
      drive(v);
      @(negedge CLK);
      Start = 1'b0;
      lat = 0;
      while (!DoneO && lat < 8) begin
         @(negedge CLK);
         lat++;
      end
      o = Out_F; ov = Overflow; un = Underflow;
   endtask

   initial begin
      logic [31:0] o;
      logic        ov, un;
      int          lat, dones;
      logic [31:0] seen;

      vecs.push_back(mk("one",        48'h4000_0000_0000, 0, 0, 127, 127, 32'h3F800000, 0, 0));
      vecs.push_back(mk("m1p5",       48'h9000_0000_0000, 0, 1, 127, 127, 32'hC0100000, 0, 0));
      vecs.push_back(mk("tie_even",   48'h4000_0040_0000, 0, 0, 127, 127, 32'h3F800000, 0, 0));
      vecs.push_back(mk("tie_odd",    48'h4000_00C0_0000, 0, 0, 127, 127, 32'h3F800002, 0, 0));
      vecs.push_back(mk("above_tie",  48'h4000_0040_0001, 0, 0, 127, 127, 32'h3F800001, 0, 0));
      vecs.push_back(mk("carry_wrap", 48'h7FFF_FFC0_0000, 0, 0, 127, 127, 32'h40000000, 0, 0));
      vecs.push_back(mk("shift_tie",  48'h8000_0080_0000, 0, 0, 127, 127, 32'h40000000, 0, 0));
      vecs.push_back(mk("shift_odd",  48'h8000_0180_0000, 0, 0, 127, 127, 32'h40000002, 0, 0));
      vecs.push_back(mk("overflow",   48'h4000_0000_0000, 0, 0, 254, 254, 32'h7F800000, 1, 0));
      vecs.push_back(mk("underflow",  48'h4000_0000_0000, 0, 0, 1,   1,   32'h00000000, 0, 1));
      vecs.push_back(mk("e254",       48'h4000_0000_0000, 0, 0, 254, 127, 32'h7F000000, 0, 0));
      vecs.push_back(mk("norm_255",   48'h9000_0000_0000, 1, 0, 254, 127, 32'hFF800000, 1, 0));
      vecs.push_back(mk("round_255",  48'h7FFF_FFC0_0000, 0, 0, 254, 127, 32'h7F800000, 1, 0));
      vecs.push_back(mk("e0",         48'h4000_0000_0000, 1, 0, 1,   126, 32'h80000000, 0, 1));
      vecs.push_back(mk("e1",         48'h4000_0000_0000, 0, 0, 1,   127, 32'h00800000, 0, 0));
      vecs.push_back(mk("qnan",       48'h4000_0000_0000, 1, 0, 255, 0,   32'h7FC00000, 0, 0));
      vecs.push_back(mk("qnan_swap",  48'h4000_0000_0000, 0, 1, 0,   255, 32'h7FC00000, 0, 0));
      vecs.push_back(mk("inf",        48'h4000_0000_0000, 1, 0, 255, 127, 32'hFF800000, 0, 0));
      vecs.push_back(mk("inf_inf",    48'h4000_0000_0000, 1, 1, 255, 255, 32'h7F800000, 0, 0));
      vecs.push_back(mk("zero",       48'h4000_0000_0000, 1, 0, 127, 0,   32'h80000000, 0, 0));

      Reset = 1'b1; Start = 1'b0; Product_in = '0; Sign_a = 0; Sign_b = 0; Exp_a = 0; Exp_b = 0;
      repeat (3) @(negedge CLK);
      check("rst_out",  Out_F, 32'h0);
      check("rst_done", {31'b0, DoneO}, 32'h0);
      check("rst_busy", {31'b0, Busy}, 32'h0);
      check("rst_flags", {30'b0, Overflow, Underflow}, 32'h0);
      Reset = 1'b0;
      @(negedge CLK);

      foreach (vecs[i]) begin
         run_op(vecs[i], o, ov, un, lat);
         check({vecs[i].name, "_lat"}, lat, 3);
         check({vecs[i].name, "_out"}, o, vecs[i].out);
         check({vecs[i].name, "_ovf"}, {31'b0, ov}, {31'b0, vecs[i].ovf});
         check({vecs[i].name, "_unf"}, {31'b0, un}, {31'b0, vecs[i].unf});
         @(negedge CLK);
         check({vecs[i].name, "_pulse_end"}, {29'b0, DoneO, Overflow, Underflow}, 32'h0);
         check({vecs[i].name, "_hold"}, Out_F, vecs[i].out);
      end

      // Start during NORM must be ignored entirely.
      drive(vecs[0]);
      @(negedge CLK);
      check("norm_busy", {31'b0, Busy}, 32'h1);
      drive(vecs[8]);
      @(negedge CLK);
      Start = 1'b0;
      dones = 0; seen = '0;
      repeat (8) begin
         @(negedge CLK);
         if (DoneO) begin
            dones++;
            seen = Out_F;
         end
      end
      check("ignore_dones", dones, 1);
      check("ignore_out", seen, 32'h3F800000);

      // Start on the DoneO cycle is accepted.
      run_op(vecs[1], o, ov, un, lat);
      check("b2b_first", o, 32'hC0100000);
      run_op(vecs[3], o, ov, un, lat);
      check("b2b_lat", lat, 3);
      check("b2b_second", o, 32'h3F800002);
      @(negedge CLK);

      // Reset while in ROUND aborts the operation.
      drive(vecs[7]);
      @(negedge CLK);
      Start = 1'b0;
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      check("abort_busy", {31'b0, Busy}, 32'h0);
      check("abort_out", Out_F, 32'h0);
      Reset = 1'b0;
      dones = 0;
      repeat (6) begin
         @(negedge CLK);
         if (DoneO) dones++;
      end
      check("abort_dones", dones, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
